// File: rtl/xor_accum_pkg.sv
// xor_accum_pkg: state encoding and count-width helper shared by the xor_accum files
package xor_accum_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t HOLD  = 2'd2;

   // ceil(log2(v)); callers pass MAX_LEN+1 so the count can hold MAX_LEN
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/xor_reduce.sv
// xor_reduce: combinational XOR reduction of a WIDTH-bit word
//   din    - word to reduce
//   parity - XOR of all bits of din
module xor_reduce #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] din,
   output logic             parity
);

   assign parity = ^din;

endmodule

// File: rtl/xor_accum.sv
// xor_accum: per-frame XOR accumulator with saturating beat count and overlength flag
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake; in_data word, in_last marks final beat
//   out_valid/out_ready   - result handshake
//   out_xor, out_parity   - XOR of frame words and its bit reduction
//   out_count, out_err    - beats counted (saturating at MAX_LEN), overlength flag
//   out_zero              - out_xor==0, present only with XOR_ACCUM_ZERO_CHECK_EN
module xor_accum
   import xor_accum_pkg::*;
#(
   parameter  int WIDTH   = 16,
   parameter  int MAX_LEN = 64,
   localparam int CW      = clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_err
`ifdef XOR_ACCUM_ZERO_CHECK_EN
  ,output logic             out_zero
`endif
);

   localparam logic [CW-1:0] MAXC = CW'(MAX_LEN);

   state_t           state, nxt;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;
   logic             err;
   logic             take;

   assign take = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = (state == HOLD) ? (out_ready ? IDLE : HOLD)
          : take            ? (in_last ? HOLD : ACCUM)
          :                   state;
   end

   // handshake flags depend on state alone, so no input-to-output paths
   always_comb begin
      in_ready  = (state != HOLD);
      out_valid = (state == HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (take) begin
         if (state == IDLE) begin
            acc   <= in_data;
            count <= CW'(1);
            err   <= 1'b0;
         end else begin
            // a beat beyond MAX_LEN is still folded into acc but flags the frame
            acc   <= acc ^ in_data;
            count <= (count == MAXC) ? count : count + 1'b1;
            err   <= err | (count == MAXC);
         end
      end
   end

   assign out_xor   = acc;
   assign out_count = count;
   assign out_err   = err;

   xor_reduce #(.WIDTH(WIDTH)) u_par (
      .din    (acc),
      .parity (out_parity)
   );

`ifdef XOR_ACCUM_ZERO_CHECK_EN
   assign out_zero = ~|acc;
`endif

endmodule
